mem_burst_arbiter: RTL and testbench

Two-master arbiter that shares the single cache-side read-burst port of mem_convertor between instruction_cache (master 0) and a data cache (master 1).
- Each master sees an Avalon-style pipelined burst-read slave.
- The arbiter forwards one master's request downstream and holds the grant until every beat of that burst has returned.
- It then re-arbitrates.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_burst_arbiter_if.sv | 24 ++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/mem_burst_arbiter.sv | 112 +++++++++++
 tb/tb_mem_burst_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_burst_arbiter: FSM state encoding, master indices and
// default bus widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StData  = 2'd2
    } arb_state_e;

    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned BURST_W_DEF = 4;

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// Avalon-style pipelined burst-read bus. The master modport issues commands; the slave
// modport answers with waitrequest and returns data beats.
interface mem_burst_arbiter_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned BURST_W = 4
);
    logic [ADDR_W-1:0]  address;
    logic               read;
    logic [BURST_W-1:0] burstcount;
    logic [DATA_W-1:0]  readdata;
    logic               waitrequest;
    logic               readdatavalid;

    modport master (
        output address, read, burstcount,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read, burstcount,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-request grant: round-robin with a last-owner pointer, or fixed priority to master 0
// when MEM_BURST_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_grant
);

`ifdef MEM_BURST_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = ^{clock, reset, i_update, i_req[1]};

    assign o_grant = i_req[M_INST] ? M_INST : M_DATA;
`else
    logic r_rr_last;

    // Pointer starts at master 1 so master 0 wins the first tie after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_last <= M_DATA;
        end else if (i_update) begin
            r_rr_last <= o_grant;
        end
    end

    always_comb begin
        o_grant = M_INST;
        if (i_req[M_INST] && i_req[M_DATA]) begin
            o_grant = ~r_rr_last;
        end else if (i_req[M_DATA]) begin
            o_grant = M_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one burst-read port between master 0 (instruction fetch) and master 1 (data),
// holding the grant until every beat returns. Option macro: MEM_BURST_ARB_FIXED_PRIO_EN.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_burst_arbiter_if.slave   m0,
    mem_burst_arbiter_if.slave   m1,
    mem_burst_arbiter_if.master  mem
);

    localparam logic [BURST_W-1:0] BeatOne = BURST_W'(1);

    arb_state_e         r_state;
    logic               r_owner;
    logic [BURST_W-1:0] r_remaining;

    logic [1:0]         w_req;
    logic               w_grant;
    logic               w_arb_update;
    logic               w_own_read;
    logic [ADDR_W-1:0]  w_own_addr;
    logic [BURST_W-1:0] w_own_bc;
    logic [BURST_W-1:0] w_beats;
    logic               w_last_beat;
    logic               w_fwd_valid;
    logic [DATA_W-1:0]  w_rdata;

    assign w_req        = {m1.read, m0.read};
    assign w_arb_update = (r_state == StIdle) && (|w_req);

    assign w_own_read   = r_owner ? m1.read       : m0.read;
    assign w_own_addr   = r_owner ? m1.address    : m0.address;
    assign w_own_bc     = r_owner ? m1.burstcount : m0.burstcount;

    // A zero burstcount is treated as a single beat.
    assign w_beats      = (w_own_bc == '0) ? BeatOne : w_own_bc;
    assign w_last_beat  = (r_remaining <= BeatOne);

    rr_arbiter2 u_rr_arbiter2 (
        .clock    (clock),
        .reset    (reset),
        .i_req    (w_req),
        .i_update (w_arb_update),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_owner     <= M_INST;
            r_remaining <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|w_req) begin
                        r_owner <= w_grant;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    // Owner withdrawing before acceptance is a protocol violation; drop it.
                    if (!w_own_read) begin
                        r_state <= StIdle;
                    end else if (!mem.waitrequest) begin
                        r_remaining <= w_beats;
                        r_state     <= StData;
                    end
                end
                StData: begin
                    if (mem.readdatavalid) begin
                        r_remaining <= r_remaining - BeatOne;
                        if (w_last_beat) begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_fwd_valid = (r_state == StData) && mem.readdatavalid;
    assign w_rdata     = mem.readdata;

    always_comb begin
        mem.address    = w_own_addr;
        mem.burstcount = w_own_bc;
        mem.read       = (r_state == StIssue) && w_own_read;

        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        if (r_state == StIssue) begin
            if (r_owner == M_DATA) begin
                m1.waitrequest = mem.waitrequest;
            end else begin
                m0.waitrequest = mem.waitrequest;
            end
        end

        m0.readdata      = w_rdata;
        m1.readdata      = w_rdata;
        m0.readdatavalid = w_fwd_valid && (r_owner == M_INST);
        m1.readdatavalid = w_fwd_valid && (r_owner == M_DATA);
    end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter; the bench plays both masters and the memory side.
module tb_mem_burst_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BURST_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m0_if ();
    mem_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m1_if ();
    mem_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) mem_if ();

    mem_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .mem   (mem_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic wr_of(input int m);
        return (m == 0) ? m0_if.waitrequest : m1_if.waitrequest;
    endfunction

    function automatic logic rdv_of(input int m);
        return (m == 0) ? m0_if.readdatavalid : m1_if.readdatavalid;
    endfunction

    function automatic logic [63:0] rdata_of(input int m);
        return (m == 0) ? m0_if.readdata : m1_if.readdata;
    endfunction

    task automatic set_req(input int m, input logic rd, input logic [31:0] a,
                           input logic [3:0] bc);
        if (m == 0) begin
            m0_if.read = rd; m0_if.address = a; m0_if.burstcount = bc;
        end else begin
            m1_if.read = rd; m1_if.address = a; m1_if.burstcount = bc;
        end
    endtask

    task automatic drop_read(input int m);
        if (m == 0) m0_if.read = 1'b0;
        else        m1_if.read = 1'b0;
    endtask

    // Waits for mem_read, holds waitrequest for 'stall' cycles, then accepts the command.
    task automatic wait_grant(input int m, input logic [31:0] a, input logic [3:0] bc,
                              input int stall, input string tag, output int lat);
        lat = 0;
        while (mem_if.read !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check({tag, " mem_read"}, 64'(mem_if.read), 64'd1);
        for (int i = 0; i < stall; i++) begin
            check({tag, " stall addr"}, 64'(mem_if.address), 64'(a));
            check({tag, " stall bc"}, 64'(mem_if.burstcount), 64'(bc));
            check({tag, " stall owner wr"}, 64'(wr_of(m)), 64'd1);
            check({tag, " stall other wr"}, 64'(wr_of(1 - m)), 64'd1);
            @(posedge clock); #1;
        end
        mem_if.waitrequest = 1'b0;
        #1;
        check({tag, " accept read"}, 64'(mem_if.read), 64'd1);
        check({tag, " accept addr"}, 64'(mem_if.address), 64'(a));
        check({tag, " accept owner wr"}, 64'(wr_of(m)), 64'd0);
        check({tag, " accept other wr"}, 64'(wr_of(1 - m)), 64'd1);
        @(posedge clock); #1;
        drop_read(m);
        mem_if.waitrequest = 1'b1;
        #1;
        check({tag, " read after accept"}, 64'(mem_if.read), 64'd0);
    endtask

    task automatic send_beats(input int m, input int n, input string tag);
        int cnt = 0;
        logic [63:0] data;
        for (int i = 0; i < n; i++) begin
            data = 64'hC0DE_0000_0000_0000 | (64'(m) << 8) | 64'(i);
            mem_if.readdata      = data;
            mem_if.readdatavalid = 1'b1;
            #1;
            if (rdv_of(m) === 1'b1) cnt++;
            check({tag, " rdata"}, rdata_of(m), data);
            check({tag, " other rdv"}, 64'(rdv_of(1 - m)), 64'd0);
            check({tag, " other wr"}, 64'(wr_of(1 - m)), 64'd1);
            @(posedge clock); #1;
        end
        mem_if.readdatavalid = 1'b0;
        #1;
        check({tag, " beats"}, 64'(cnt), 64'(n));
    endtask

    task automatic stray_beat(input string tag);
        mem_if.readdatavalid = 1'b1;
        #1;
        check({tag, " stray m0 rdv"}, 64'(m0_if.readdatavalid), 64'd0);
        check({tag, " stray m1 rdv"}, 64'(m1_if.readdatavalid), 64'd0);
        mem_if.readdatavalid = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int lat;
        logic [31:0] addr_tab [2];
        int first;

        set_req(0, 1'b0, 32'h0, 4'd0);
        set_req(1, 1'b0, 32'h0, 4'd0);
        mem_if.readdata      = '0;
        mem_if.waitrequest   = 1'b1;
        mem_if.readdatavalid = 1'b0;

        #3;
        check("reset mem_read", 64'(mem_if.read), 64'd0);
        check("reset m0 wr", 64'(m0_if.waitrequest), 64'd1);
        check("reset m1 wr", 64'(m1_if.waitrequest), 64'd1);
        check("reset m0 rdv", 64'(m0_if.readdatavalid), 64'd0);
        check("reset m1 rdv", 64'(m1_if.readdatavalid), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;

        // Single m0 burst of 8.
        set_req(0, 1'b1, 32'h0040_0000, 4'd8);
        wait_grant(0, 32'h0040_0000, 4'd8, 1, "single", lat);
        check("single latency", 64'(lat), 64'd1);
        send_beats(0, 8, "single");
        check("single idle read", 64'(mem_if.read), 64'd0);
        stray_beat("single idle");

        // Simultaneous requests right after reset: m0 first, m1 after one IDLE cycle.
        pulse_reset();
        set_req(0, 1'b1, 32'h0040_0000, 4'd8);
        set_req(1, 1'b1, 32'h0000_1000, 4'd8);
        wait_grant(0, 32'h0040_0000, 4'd8, 1, "tie m0", lat);
        send_beats(0, 8, "tie m0");
        check("tie gap read", 64'(mem_if.read), 64'd0);
        check("tie gap m1 wr", 64'(m1_if.waitrequest), 64'd1);
        wait_grant(1, 32'h0000_1000, 4'd8, 1, "tie m1", lat);
        check("tie m1 latency", 64'(lat), 64'd1);
        send_beats(1, 8, "tie m1");

        // Following tie goes to m0 in both modes; downstream stalls for 5 cycles.
        set_req(0, 1'b1, 32'h0040_0040, 4'd8);
        set_req(1, 1'b1, 32'h0000_1040, 4'd4);
        wait_grant(0, 32'h0040_0040, 4'd8, 5, "stall m0", lat);
        send_beats(0, 8, "stall m0");
        wait_grant(1, 32'h0000_1040, 4'd4, 1, "stall m1", lat);
        send_beats(1, 4, "stall m1");

        // m1 requests in the middle of an m0 burst.
        set_req(0, 1'b1, 32'h0040_0080, 4'd8);
        wait_grant(0, 32'h0040_0080, 4'd8, 1, "mid m0", lat);
        send_beats(0, 4, "mid m0a");
        set_req(1, 1'b1, 32'h0000_2000, 4'd8);
        send_beats(0, 4, "mid m0b");
        check("mid gap read", 64'(mem_if.read), 64'd0);
        wait_grant(1, 32'h0000_2000, 4'd8, 1, "mid m1", lat);
        check("mid m1 latency", 64'(lat), 64'd1);
        send_beats(1, 8, "mid m1");
        stray_beat("mid after");

        // After an m0-only burst, round-robin hands the next tie to m1.
        set_req(0, 1'b1, 32'h0040_00C0, 4'd2);
        wait_grant(0, 32'h0040_00C0, 4'd2, 1, "rr pre", lat);
        send_beats(0, 2, "rr pre");
        addr_tab[0] = 32'h0040_0100;
        addr_tab[1] = 32'h0000_3000;
        set_req(0, 1'b1, addr_tab[0], 4'd2);
        set_req(1, 1'b1, addr_tab[1], 4'd2);
`ifdef MEM_BURST_ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        wait_grant(first, addr_tab[first], 4'd2, 1, "rr first", lat);
        send_beats(first, 2, "rr first");
        wait_grant(1 - first, addr_tab[1 - first], 4'd2, 1, "rr second", lat);
        send_beats(1 - first, 2, "rr second");

        // Reset after beat 3 of 8, then a clean m1 burst of 4.
        set_req(0, 1'b1, 32'h0040_0200, 4'd8);
        wait_grant(0, 32'h0040_0200, 4'd8, 1, "rst m0", lat);
        send_beats(0, 3, "rst m0");
        mem_if.readdatavalid = 1'b1;
        reset = 1'b1;
        #1;
        check("rst async mem_read", 64'(mem_if.read), 64'd0);
        check("rst async m0 rdv", 64'(m0_if.readdatavalid), 64'd0);
        check("rst async m0 wr", 64'(m0_if.waitrequest), 64'd1);
        check("rst async m1 wr", 64'(m1_if.waitrequest), 64'd1);
        mem_if.readdatavalid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        set_req(1, 1'b1, 32'h0000_4000, 4'd4);
        wait_grant(1, 32'h0000_4000, 4'd4, 1, "rst m1", lat);
        send_beats(1, 4, "rst m1");
        stray_beat("rst m1 after");

        // burstcount 0 returns exactly one beat.
        set_req(0, 1'b1, 32'h0040_0300, 4'd0);
        wait_grant(0, 32'h0040_0300, 4'd0, 1, "bc0", lat);
        send_beats(0, 1, "bc0");
        check("bc0 idle read", 64'(mem_if.read), 64'd0);
        stray_beat("bc0 after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
